// File: rtl/stage2_relu_maxpool_pkg.sv
// Shared sizing defaults and pooling-phase helper for the stage-2 ReLU + 2x2 max-pool post-processor.
// The phase is decoded from the pixel's column and row parity only.
package stage2_relu_maxpool_pkg;

  localparam int ST2_ACI_BW     = 26;
  localparam int ST2_BIAS_BW    = 16;
  localparam int ST2_POOL_OBW   = 16;
  localparam int ST2_POOL_SHIFT = 4;
  localparam int ST2_POOL_W     = 8;
  localparam int ST2_POOL_H     = 8;

  typedef enum logic [1:0] {
    PH_HOLD,
    PH_ROW,
    PH_EMIT
  } pool_ph_e;

  // Even column: stash the left pixel. Odd column: fold into the row buffer (even row) or emit (odd row).
  function automatic pool_ph_e pool_phase(input logic x_odd, input logic y_odd);
    if (!x_odd) return PH_HOLD;
    return y_odd ? PH_EMIT : PH_ROW;
  endfunction

endpackage

// File: rtl/stage2_bias_relu.sv
// Bias add (S1), then ReLU/shift/saturate (S2); 2-cycle latency, no backpressure.
// Clear or reset drops both pipeline valids; the data registers are never cleared.
module stage2_bias_relu #(
  parameter int ACI_BW  = 26,
  parameter int BIAS_BW = 16,
  parameter int OBW     = 16,
  parameter int SHIFT   = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      in_vld,
  input  logic signed [ACI_BW-1:0]  acc,
  input  logic signed [BIAS_BW-1:0] bias,
  output logic                      out_vld,
  output logic [OBW-1:0]            out_dat
);

  localparam int SW = ACI_BW + 1;
  localparam logic [SW-1:0] SAT = {{(SW - OBW + 1){1'b0}}, {(OBW - 1){1'b1}}};

  logic                 s1_vld;
  logic signed [SW-1:0] s1_sum;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] shifted;
  logic [OBW-1:0]       relu_sat;

  always_comb begin
    sum      = {acc[ACI_BW-1], acc} + {{(SW - BIAS_BW){bias[BIAS_BW-1]}}, bias};
    shifted  = s1_sum >>> SHIFT;
    relu_sat = '0;
    if (s1_sum[SW-1])
      relu_sat = '0;
    else if ($unsigned(shifted) > SAT)
      relu_sat = SAT[OBW-1:0];
    else
      relu_sat = shifted[OBW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      s1_vld  <= 1'b0;
      out_vld <= 1'b0;
    end else begin
      s1_vld  <= in_vld;
      out_vld <= s1_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (in_vld) s1_sum <= sum;
    if (s1_vld) out_dat <= relu_sat;
  end

endmodule

// File: rtl/stage2_relu_maxpool.sv
// Per-channel bias + ReLU + 2x2/stride-2 max pool over a raster stream; 3-cycle input-to-output latency.
// No backpressure: input may be gapped, one pooled pulse per completed window.
module stage2_relu_maxpool
  import stage2_relu_maxpool_pkg::*;
#(
  parameter int ACI_BW  = ST2_ACI_BW,
  parameter int BIAS_BW = ST2_BIAS_BW,
  parameter int OBW     = ST2_POOL_OBW,
  parameter int SHIFT   = ST2_POOL_SHIFT,
  parameter int FMAP_W  = ST2_POOL_W,
  parameter int FMAP_H  = ST2_POOL_H
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_clear,
  input  logic                      i_in_valid,
  input  logic signed [ACI_BW-1:0]  i_ot_ci_acc,
  input  logic signed [BIAS_BW-1:0] i_bias,
  output logic                      o_ot_valid,
  output logic [OBW-1:0]            o_ot_pool,
  output logic                      o_frame_done
);

  localparam int HW = (FMAP_W > 2) ? $clog2(FMAP_W / 2) : 1;
  localparam int XW = HW + 1;
  localparam int YW = (FMAP_H > 2) ? $clog2(FMAP_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(FMAP_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FMAP_H - 1);

  logic           s2_vld;
  logic [OBW-1:0] s2_dat;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [HW-1:0]  col;
  logic [OBW-1:0] hold;
  logic [OBW-1:0] rowbuf [FMAP_W/2];
  logic [OBW-1:0] pair_max;
  pool_ph_e       phase;

  function automatic logic [OBW-1:0] umax(input logic [OBW-1:0] a, input logic [OBW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  stage2_bias_relu #(
    .ACI_BW (ACI_BW),
    .BIAS_BW(BIAS_BW),
    .OBW    (OBW),
    .SHIFT  (SHIFT)
  ) u_bias_relu (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (i_clear),
    .in_vld (i_in_valid),
    .acc    (i_ot_ci_acc),
    .bias   (i_bias),
    .out_vld(s2_vld),
    .out_dat(s2_dat)
  );

  always_comb begin
    col      = x[XW-1:1];
    phase    = pool_phase(x[0], y[0]);
    pair_max = umax(hold, s2_dat);
  end

  // hold and rowbuf need no reset: each slot is written before its first read in a frame.
  always_ff @(posedge clk) begin
    if (s2_vld) begin
      case (phase)
        PH_HOLD: hold <= s2_dat;
        PH_ROW:  rowbuf[col] <= pair_max;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x            <= '0;
      y            <= '0;
      o_ot_valid   <= 1'b0;
      o_frame_done <= 1'b0;
      o_ot_pool    <= '0;
    end else if (i_clear) begin
      x            <= '0;
      y            <= '0;
      o_ot_valid   <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_ot_valid   <= 1'b0;
      o_frame_done <= 1'b0;
      if (s2_vld) begin
        if (x == X_LAST) begin
          x <= '0;
          y <= (y == Y_LAST) ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
        if (phase == PH_EMIT) begin
          o_ot_pool    <= umax(rowbuf[col], pair_max);
          o_ot_valid   <= 1'b1;
          o_frame_done <= (x == X_LAST) && (y == Y_LAST);
        end
      end
    end
  end

endmodule

// File: tb/tb_stage2_relu_maxpool.sv
// Randomized and directed bench for stage2_relu_maxpool against a frame-array pooling model.
// Expected pulses carry their due cycle; one compare process checks outputs every cycle.
module tb_stage2_relu_maxpool;

  localparam int W     = 8;
  localparam int H     = 8;
  localparam int SHIFT = 4;
  localparam int OBW   = 16;
  localparam int NPX   = W * H;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_clear;
  logic        i_in_valid;
  logic [25:0] i_ot_ci_acc;
  logic [15:0] i_bias;
  logic        o_ot_valid;
  logic [15:0] o_ot_pool;
  logic        o_frame_done;

  stage2_relu_maxpool dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_clear     (i_clear),
    .i_in_valid  (i_in_valid),
    .i_ot_ci_acc (i_ot_ci_acc),
    .i_bias      (i_bias),
    .o_ot_valid  (o_ot_valid),
    .o_ot_pool   (o_ot_pool),
    .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { longint v; bit done; int due; } exp_t;
  typedef struct { longint v; bit done; } obs_t;

  int     cyc = 0;
  int     n_chk = 0;
  int     n_fail = 0;
  bit     chk_en = 0;
  int     pool_rst_due = -1;
  longint last_pool = 0;
  longint lb = 0;
  exp_t   q[$];
  obs_t   obs[$];
  obs_t   obs_ref[$];
  longint px[H][W];
  int     mx = 0;
  int     my = 0;
  longint fa[NPX];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint px_val(input longint acc, input longint bias);
    longint s;
    longint lim;
    s   = acc + bias;
    lim = (longint'(1) << (OBW - 1)) - 1;
    if (s < 0) return 0;
    s = s / (longint'(1) << SHIFT);
    return (s > lim) ? lim : s;
  endfunction

  function automatic longint max4(input longint a, input longint b, input longint c, input longint d);
    longint m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  task automatic model_accept(input longint acc, input longint bias);
    exp_t e;
    px[my][mx] = px_val(acc, bias);
    if ((mx % 2 == 1) && (my % 2 == 1)) begin
      e.v    = max4(px[my-1][mx-1], px[my-1][mx], px[my][mx-1], px[my][mx]);
      e.done = (mx == W - 1) && (my == H - 1);
      e.due  = cyc + 3;
      q.push_back(e);
    end
    mx++;
    if (mx == W) begin
      mx = 0;
      my = (my == H - 1) ? 0 : my + 1;
    end
  endtask

  // One clock of stimulus, driven just after the rising edge.
  task automatic step(input bit vld, input longint acc, input longint bias, input bit clr, input bit rst);
    @(posedge clk);
    #1;
    i_in_valid  = vld;
    i_ot_ci_acc = acc[25:0];
    i_bias      = bias[15:0];
    i_clear     = clr;
    reset_n     = !rst;
    if (rst || clr) begin
      mx = 0;
      my = 0;
      while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
      if (rst) pool_rst_due = cyc + 1;
    end else if (vld) begin
      model_accept(acc, bias);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, lb, 0, 0);
  endtask

  task automatic run_px(input longint bias, input int npx, input int gapmax);
    lb = bias;
    for (int i = 0; i < npx; i++) begin
      step(1, fa[i], bias, 0, 0);
      if (gapmax > 0) idle($urandom_range(0, gapmax));
    end
  endtask

  task automatic fill_const(input longint v);
    for (int i = 0; i < NPX; i++) fa[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NPX; i++)
      fa[i] = longint'($urandom_range(0, (1 << 26) - 1)) - (longint'(1) << 25);
  endtask

  function automatic longint rand_bias();
    return longint'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic check_all(input string name, input longint v);
    chk({name, "_cnt"}, obs.size(), 16);
    foreach (obs[i]) begin
      chk({name, "_val"}, obs[i].v, v);
      chk({name, "_done"}, obs[i].done, (i == obs.size() - 1));
    end
  endtask

  // Compare process: every cycle, the DUT outputs must match the queued expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      bit   ev;
      if (cyc == pool_rst_due) last_pool = 0;
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("valid", o_ot_valid, ev);
      if (ev) begin
        e = q.pop_front();
        chk("pool", o_ot_pool, e.v);
        chk("frame_done", o_frame_done, e.done);
        last_pool = e.v;
      end else begin
        chk("pool_hold", o_ot_pool, last_pool);
        chk("done_idle", o_frame_done, 0);
      end
      if (o_ot_valid) obs.push_back('{v: o_ot_pool, done: o_frame_done});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int     idx[4];
    longint b;
    reset_n     = 1'b0;
    i_clear     = 1'b0;
    i_in_valid  = 1'b0;
    i_ot_ci_acc = '0;
    i_bias      = '0;

    chk("model_uniform", px_val(256, 0), 16);
    chk("model_relu", px_val(-100, 50), 0);
    chk("model_shift", px_val(-100, 200), 6);
    chk("model_sat", px_val((1 << 25) - 1, (1 << 15) - 1), 32767);

    repeat (3) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("reset_valid", o_ot_valid, 0);
    chk("reset_pool", o_ot_pool, 0);
    chk("reset_done", o_frame_done, 0);
    chk_en = 1;

    // Uniform frame
    obs.delete();
    fill_const(256);
    run_px(0, NPX, 0);
    idle(6);
    check_all("uniform", 16);

    // ReLU: negative sums clamp to zero, then a positive shifted result
    obs.delete();
    fill_const(-100);
    run_px(50, NPX, 0);
    idle(6);
    check_all("relu_neg", 0);
    obs.delete();
    run_px(200, NPX, 0);
    idle(6);
    check_all("relu_pos", 6);

    // Max selection with the maximum at each window position
    idx = '{0, 1, W, W + 1};
    for (int p = 0; p < 4; p++) begin
      obs.delete();
      fill_const(0);
      for (int k = 0; k < 4; k++) fa[idx[k]] = 16 * (((k + 4 - p - 1) % 4) + 1);
      run_px(0, NPX, 0);
      idle(6);
      chk("maxsel_cnt", obs.size(), 16);
      if (obs.size() == 16) begin
        chk("maxsel_first", obs[0].v, 4);
        for (int i = 1; i < 16; i++) chk("maxsel_rest", obs[i].v, 0);
      end
    end

    // Saturation
    obs.delete();
    fill_const((1 << 25) - 1);
    run_px((1 << 15) - 1, NPX, 0);
    idle(6);
    check_all("sat", 32767);

    // Gapped vs ungapped: identical values and order
    fill_rand();
    b = rand_bias();
    obs.delete();
    run_px(b, NPX, 0);
    idle(6);
    obs_ref = obs;
    obs.delete();
    run_px(b, NPX, 5);
    idle(6);
    chk("gap_cnt", obs.size(), obs_ref.size());
    if (obs.size() == obs_ref.size())
      foreach (obs[i]) chk("gap_order", obs[i].v, obs_ref[i].v);

    // Random back-to-back frames with per-frame bias
    for (int f = 0; f < 3; f++) begin
      fill_rand();
      run_px(rand_bias(), NPX, (f == 1) ? 2 : 0);
    end
    idle(6);

    // Mid-frame reset after 37 samples, then a full frame
    fill_const(512);
    run_px(0, 37, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("midrst_valid", o_ot_valid, 0);
    chk("midrst_pool", o_ot_pool, 0);
    chk("midrst_done", o_frame_done, 0);
    obs.delete();
    fill_rand();
    run_px(rand_bias(), NPX, 0);
    idle(6);
    chk("midrst_cnt", obs.size(), 16);

    // Mid-frame clear coinciding with a valid sample, which must be dropped
    fill_rand();
    b = rand_bias();
    run_px(b, 37, 0);
    step(1, (1 << 24), b, 1, 0);
    obs.delete();
    fill_rand();
    run_px(b, NPX, 0);
    idle(6);
    chk("clear_cnt", obs.size(), 16);
    if (obs.size() > 0) chk("clear_last_done", obs[obs.size()-1].done, 1);

    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stage2_relu_maxpool.md
# stage2_relu_maxpool

Post-processing stage directly downstream of the stage-2 channel accumulator. Per output channel, it adds a bias to each raster-ordered conv accumulator sample, applies ReLU, shifts and saturates the result to the output feature width, then performs 2x2/stride-2 max pooling with a half-width row buffer. One instance per output channel. It emits the pooled map in raster order to the next stage.

## Interface
Parameters:
- `ACI_BW`, default 26: input accumulator width (signed).
- `BIAS_BW`, default 16: bias width (signed).
- `OBW`, default 16: output width (signed; values are always ≥ 0).
- `SHIFT`, default 4: arithmetic right shift applied after ReLU.
- `FMAP_W`, default 8: conv output width. Must be even and ≥ 2.
- `FMAP_H`, default 8: conv output height. Must be even and ≥ 2.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: synchronous, active-low reset.
- `i_clear` in 1: synchronous soft restart (counters and pipeline valids only).
- `i_in_valid` in 1: accumulator sample valid (`o_ot_valid` of the upstream stage).
- `i_ot_ci_acc` in `ACI_BW`: signed accumulator sample.
- `i_bias` in `BIAS_BW`: signed bias. Must be held stable for the whole frame.
- `o_ot_valid` out 1: pooled sample valid, 1-cycle pulse.
- `o_ot_pool` out `OBW`: pooled sample.
- `o_frame_done` out 1: pulses together with the last pooled sample of a frame.

## Operation
- No backpressure. Input may be gapped arbitrarily; each `i_in_valid` cycle carries exactly one pixel in raster order.
- S1 (register): `sum = sext(acc) + sext(bias)`, computed at width `ACI_BW+1`.
- S2 (register):
  - `sum < 0` → 0.
  - Otherwise `sum >>> SHIFT`.
  - Clamp to `2^(OBW-1)-1`.
- Pool counters:
  - `x` in 0..FMAP_W-1 and `y` in 0..FMAP_H-1.
  - Advance on each S2-valid cycle.
  - `x` wraps to 0 and increments `y`; `y` wraps to 0 after the last pixel.
- Pool datapath. Values are non-negative, so comparisons are unsigned.
  - Even `x`: `hold <= v`.
  - Odd `x`, even `y`: `rowbuf[x>>1] <= max(hold, v)`.
  - Odd `x`, odd `y`: `o_ot_pool <= max(rowbuf[x>>1], hold, v)` and `o_ot_valid <= 1`.
- `o_frame_done` is high on the pooled output for `x = FMAP_W-1`, `y = FMAP_H-1`.
- Output count per frame: `(FMAP_W/2)*(FMAP_H/2)`. Defaults give 16.
- `i_clear` or `reset_n = 0`:
  - `x`, `y`, S1/S2 valids, `o_ot_valid`, and `o_frame_done` go to 0. Samples in flight are discarded.
  - `rowbuf` and `hold` are not cleared; they are always written before they are read.
- `i_clear` and `i_in_valid` in the same cycle: clear wins and the sample is dropped.
- Reset values of outputs: `o_ot_valid = 0`, `o_ot_pool = 0`, `o_frame_done = 0`.

## Timing
- Latency: the S1 register, the S2 register, and the output register each add one cycle. `o_ot_valid` and `o_frame_done` rise exactly 3 cycles after the `i_in_valid` of the bottom-right pixel of each 2x2 window.
- `o_ot_pool` holds its value between pulses.
- Throughput: 1 sample/cycle sustained. Back-to-back frames need no idle gap; counter wrap and the next frame's first pixel may occur in the same cycle.
- `i_bias` is sampled in S1 only. A change mid-frame affects only the pixels that enter S1 after the change.

## Structure
- Add to `stage2_defines_cnn_core.v`:
  - `ST2_POOL_W`, `ST2_POOL_H`, `ST2_POOL_OBW`, `ST2_POOL_SHIFT`, `ST2_BIAS_BW`.
  - `ACI_BW` is already present and is reused.
- Sub-module `stage2_bias_relu` implements S1 and S2: bias add, ReLU, shift, saturate, and the valid pipeline.
- The top level contains the counters, `hold`, `rowbuf` (FMAP_W/2 × OBW, registers), and the output register.

## Test plan
- **Uniform frame.** Stimulus: 64 samples of acc = 256, bias = 0, SHIFT = 4. Required: 16 outputs of 16. `o_frame_done` on the 16th output only.
- **Negative/ReLU.** Stimulus: acc = −100, bias = 50. Required: every output is 0. Then acc = −100, bias = 200 → every output is 6 (100>>4).
- **Max selection.** Stimulus: first window values 1, 2 (row 0) and 3, 4 (row 1) scaled by 16; all other pixels 0. Required: first output = 4, others 0. Repeat with the maximum placed at each of the four positions.
- **Saturation.** Stimulus: acc = 2^25−1, bias = 2^15−1. Required: every output is 32767 (`OBW` = 16).
- **Gapped input.** Stimulus: random 0–5 idle cycles between samples. Required: output values and ordering identical to the ungapped run. Each pulse arrives exactly 3 cycles after its window-completing input.
- **Mid-frame reset and clear.** Stimulus: `reset_n` low for 1 cycle after 37 samples, then a full frame. Required: all outputs go to 0 on the next edge, no stale pulse, and the following frame is correct. Repeat with `i_clear` asserted in the same cycle as `i_in_valid`: that sample is dropped.
